// File: rtl/controlador_de_partida_if.sv
// Shot/status bus between the match sequencer and its environment.
// The master side drives the player controls and the map; the slave side reports match status.
interface controlador_de_partida_if;
  logic       iniciar;
  logic       botao_confirmar;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic [6:0] mapa0;
  logic [6:0] mapa1;
  logic [6:0] mapa2;
  logic [6:0] mapa3;
  logic [6:0] mapa4;
  logic       enable;
  logic       confirmar;
  logic [3:0] tentativas_restantes;
  logic [3:0] acertos;
  logic       ultimo_acerto;
  logic       coord_invalida;
  logic       vitoria;
  logic       derrota;
  logic [2:0] estado;

  modport master (
    output iniciar, botao_confirmar, coordColuna, coordLinha,
           mapa0, mapa1, mapa2, mapa3, mapa4,
    input  enable, confirmar, tentativas_restantes, acertos,
           ultimo_acerto, coord_invalida, vitoria, derrota, estado
  );

  modport slave (
    input  iniciar, botao_confirmar, coordColuna, coordLinha,
           mapa0, mapa1, mapa2, mapa3, mapa4,
    output enable, confirmar, tentativas_restantes, acertos,
           ultimo_acerto, coord_invalida, vitoria, derrota, estado
  );
endinterface

// File: rtl/controlador_de_partida.sv
// Turn sequencer for one battleship match on the 5x7 LED board: validates shots,
// pulses confirmar to the attack manager, and tracks hits, attempts and the match outcome.
module controlador_de_partida #(
  parameter int MAX_TENTATIVAS = 10,
  parameter int TOTAL_ALVOS    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  controlador_de_partida_if.slave   bus
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    JOGANDO = 3'd1,
    DISPARO = 3'd2,
    AVALIA  = 3'd3,
    VITORIA = 3'd4,
    DERROTA = 3'd5
  } estado_t;

  estado_t     estado_q, estado_d;
  logic        botao_anterior_q;
  logic [34:0] ja_atacado_q, ja_atacado_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  acertos_q, acertos_d;
  logic [3:0]  tentativas_q, tentativas_d;
  logic        ultimo_q, ultimo_d;
  logic        invalida_q, invalida_d;

  logic        borda;
  logic        coord_ok;
  logic [5:0]  idx_w;
  logic        ja_w;
  logic [34:0] mapa_flat;
  logic        acerto;

  // Cell index is col*7 + row, matching the column-major layout of mapa_flat.
  assign mapa_flat = {bus.mapa4, bus.mapa3, bus.mapa2, bus.mapa1, bus.mapa0};
  assign borda     = bus.botao_confirmar & ~botao_anterior_q;
  assign coord_ok  = (bus.coordColuna <= 3'd4) && (bus.coordLinha <= 3'd6);
  assign idx_w     = 6'(bus.coordColuna) * 6'd7 + 6'(bus.coordLinha);
  assign ja_w      = coord_ok && ja_atacado_q[idx_w];
  assign acerto    = mapa_flat[idx_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q         <= OCIOSO;
      botao_anterior_q <= 1'b0;
      ja_atacado_q     <= '0;
      idx_q            <= '0;
      acertos_q        <= '0;
      tentativas_q     <= '0;
      ultimo_q         <= 1'b0;
      invalida_q       <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      botao_anterior_q <= bus.botao_confirmar;
      ja_atacado_q     <= ja_atacado_d;
      idx_q            <= idx_d;
      acertos_q        <= acertos_d;
      tentativas_q     <= tentativas_d;
      ultimo_q         <= ultimo_d;
      invalida_q       <= invalida_d;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    ja_atacado_d = ja_atacado_q;
    idx_d        = idx_q;
    acertos_d    = acertos_q;
    tentativas_d = tentativas_q;
    ultimo_d     = ultimo_q;
    invalida_d   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (bus.iniciar) begin
          estado_d     = JOGANDO;
          tentativas_d = 4'(MAX_TENTATIVAS);
          acertos_d    = '0;
          ja_atacado_d = '0;
          ultimo_d     = 1'b0;
        end
      end
      JOGANDO: begin
        if (borda) begin
          if (!coord_ok || ja_w) begin
            invalida_d = 1'b1;
          end else begin
            idx_d               = idx_w;
            ja_atacado_d[idx_w] = 1'b1;
            estado_d            = DISPARO;
          end
        end
      end
      DISPARO: begin
        if (acerto && (acertos_q != 4'hF)) acertos_d = acertos_q + 4'd1;
        if (tentativas_q != 4'd0) tentativas_d = tentativas_q - 4'd1;
        ultimo_d = acerto;
        estado_d = AVALIA;
      end
      AVALIA: begin
        // Victory is checked first so a hit on the final attempt still wins.
        if (acertos_q == 4'(TOTAL_ALVOS))  estado_d = VITORIA;
        else if (tentativas_q == 4'd0)     estado_d = DERROTA;
        else                               estado_d = JOGANDO;
      end
      VITORIA, DERROTA: begin
        if (bus.iniciar) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    bus.enable               = (estado_q == JOGANDO) || (estado_q == DISPARO) || (estado_q == AVALIA);
    bus.confirmar            = (estado_q == DISPARO);
    bus.vitoria              = (estado_q == VITORIA);
    bus.derrota              = (estado_q == DERROTA);
    bus.estado               = estado_q;
    bus.tentativas_restantes = tentativas_q;
    bus.acertos              = acertos_q;
    bus.ultimo_acerto        = ultimo_q;
    bus.coord_invalida       = invalida_q;
  end

endmodule

// File: tb/tb_controlador_de_partida.sv
// Directed bench for the battleship match sequencer.
module tb_controlador_de_partida;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  controlador_de_partida_if bus ();

  controlador_de_partida #(.MAX_TENTATIVAS(10), .TOTAL_ALVOS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic start_match();
    @(negedge clock); bus.iniciar = 1'b1;
    @(negedge clock); bus.iniciar = 1'b0;
  endtask

  task automatic pulse_iniciar();
    @(negedge clock); bus.iniciar = 1'b1;
    @(negedge clock); bus.iniciar = 1'b0;
  endtask

  // Presses the button once and observes the four cycles that follow.
  task automatic fire(input logic [2:0] c, input logic [2:0] l,
                      output int conf_first, output int conf_cnt, output int inv_cnt);
    @(negedge clock);
    bus.coordColuna = c; bus.coordLinha = l; bus.botao_confirmar = 1'b1;
    conf_cnt = 0; inv_cnt = 0;
    @(negedge clock);
    bus.botao_confirmar = 1'b0;
    conf_first = int'(bus.confirmar);
    conf_cnt += int'(bus.confirmar); inv_cnt += int'(bus.coord_invalida);
    repeat (3) begin
      @(negedge clock);
      conf_cnt += int'(bus.confirmar); inv_cnt += int'(bus.coord_invalida);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.iniciar = 1'b0; bus.botao_confirmar = 1'b0;
    bus.coordColuna = '0; bus.coordLinha = '0;
    bus.mapa0 = 7'b1110001; bus.mapa1 = 7'b0100000; bus.mapa2 = '0;
    bus.mapa3 = '0; bus.mapa4 = 7'b1110000;
    repeat (2) @(negedge clock);
    total++; if (bus.estado !== 3'd0) begin bad++; $display("FAIL reset_estado got=%0d exp=0", bus.estado); end
    total++; if ({bus.enable, bus.confirmar, bus.vitoria, bus.derrota, bus.coord_invalida, bus.ultimo_acerto} !== 6'b0)
      begin bad++; $display("FAIL reset_flags got=%b exp=000000", {bus.enable, bus.confirmar, bus.vitoria, bus.derrota, bus.coord_invalida, bus.ultimo_acerto}); end
    total++; if ({bus.acertos, bus.tentativas_restantes} !== 8'h00)
      begin bad++; $display("FAIL reset_counts got=%h exp=00", {bus.acertos, bus.tentativas_restantes}); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    total++; if (bus.estado !== 3'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", bus.estado); end
  endtask

  task automatic test_start();
    start_match();
    total++; if (bus.estado !== 3'd1) begin bad++; $display("FAIL start_estado got=%0d exp=1", bus.estado); end
    total++; if (bus.tentativas_restantes !== 4'd10) begin bad++; $display("FAIL start_tent got=%0d exp=10", bus.tentativas_restantes); end
    total++; if (bus.acertos !== 4'd0) begin bad++; $display("FAIL start_acertos got=%0d exp=0", bus.acertos); end
    total++; if ({bus.enable, bus.confirmar} !== 2'b10) begin bad++; $display("FAIL start_en_conf got=%b exp=10", {bus.enable, bus.confirmar}); end
  endtask

  task automatic test_hit_miss();
    int cf, cc, ic;
    fire(3'd0, 3'd0, cf, cc, ic);
    total++; if (cf !== 1) begin bad++; $display("FAIL hit_conf_latency got=%0d exp=1", cf); end
    total++; if (cc !== 1) begin bad++; $display("FAIL hit_conf_count got=%0d exp=1", cc); end
    total++; if ({bus.acertos, bus.ultimo_acerto, bus.tentativas_restantes} !== {4'd1, 1'b1, 4'd9})
      begin bad++; $display("FAIL hit_counts got=a%0d u%0d t%0d exp=a1 u1 t9", bus.acertos, bus.ultimo_acerto, bus.tentativas_restantes); end
    total++; if (bus.estado !== 3'd1) begin bad++; $display("FAIL hit_back_to_play got=%0d exp=1", bus.estado); end
    fire(3'd2, 3'd3, cf, cc, ic);
    total++; if ({bus.acertos, bus.ultimo_acerto, bus.tentativas_restantes} !== {4'd1, 1'b0, 4'd8})
      begin bad++; $display("FAIL miss_counts got=a%0d u%0d t%0d exp=a1 u0 t8", bus.acertos, bus.ultimo_acerto, bus.tentativas_restantes); end
  endtask

  task automatic test_invalid();
    int cf, cc, ic;
    logic [2:0] cs [3] = '{3'd0, 3'd5, 3'd1};
    logic [2:0] ls [3] = '{3'd0, 3'd2, 3'd7};
    for (int i = 0; i < 3; i++) begin
      fire(cs[i], ls[i], cf, cc, ic);
      total++; if (ic !== 1 || cc !== 0)
        begin bad++; $display("FAIL invalid_%0d got=inv%0d conf%0d exp=inv1 conf0", i, ic, cc); end
    end
    total++; if ({bus.acertos, bus.tentativas_restantes, bus.estado} !== {4'd1, 4'd8, 3'd1})
      begin bad++; $display("FAIL invalid_counts got=a%0d t%0d e%0d exp=a1 t8 e1", bus.acertos, bus.tentativas_restantes, bus.estado); end
  endtask

  task automatic test_hold();
    int cc = 0;
    @(negedge clock);
    bus.coordColuna = 3'd2; bus.coordLinha = 3'd4; bus.botao_confirmar = 1'b1;
    repeat (20) begin @(negedge clock); cc += int'(bus.confirmar); end
    bus.botao_confirmar = 1'b0;
    repeat (3) begin @(negedge clock); cc += int'(bus.confirmar); end
    total++; if (cc !== 1) begin bad++; $display("FAIL hold_one_shot got=%0d exp=1", cc); end
    total++; if (bus.tentativas_restantes !== 4'd7) begin bad++; $display("FAIL hold_tent got=%0d exp=7", bus.tentativas_restantes); end
  endtask

  task automatic test_victory();
    int cf, cc, ic;
    logic [2:0] vc [7] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd4, 3'd4, 3'd4};
    logic [2:0] vl [7] = '{3'd4, 3'd5, 3'd6, 3'd5, 3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 7; i++) begin
      fire(vc[i], vl[i], cf, cc, ic);
      total++; if (bus.acertos !== 4'(i + 2)) begin bad++; $display("FAIL win_acertos_%0d got=%0d exp=%0d", i, bus.acertos, i + 2); end
    end
    total++; if ({bus.estado, bus.vitoria, bus.derrota, bus.enable} !== {3'd4, 1'b1, 1'b0, 1'b0})
      begin bad++; $display("FAIL win_state got=e%0d v%0d d%0d en%0d exp=e4 v1 d0 en0", bus.estado, bus.vitoria, bus.derrota, bus.enable); end
    total++; if (bus.tentativas_restantes !== 4'd0) begin bad++; $display("FAIL win_tent got=%0d exp=0", bus.tentativas_restantes); end
    fire(3'd1, 3'd1, cf, cc, ic);
    total++; if (cc !== 0 || bus.estado !== 3'd4 || bus.acertos !== 4'd8)
      begin bad++; $display("FAIL win_ignores_button got=conf%0d e%0d a%0d exp=conf0 e4 a8", cc, bus.estado, bus.acertos); end
    pulse_iniciar();
    total++; if (bus.estado !== 3'd0) begin bad++; $display("FAIL win_to_idle got=%0d exp=0", bus.estado); end
  endtask

  task automatic test_defeat();
    int cf, cc, ic;
    start_match();
    for (int i = 0; i < 10; i++) begin
      if (i < 7) fire(3'd2, 3'(i), cf, cc, ic);
      else       fire(3'd3, 3'(i - 7), cf, cc, ic);
    end
    total++; if ({bus.estado, bus.derrota, bus.vitoria} !== {3'd5, 1'b1, 1'b0})
      begin bad++; $display("FAIL lose_state got=e%0d d%0d v%0d exp=e5 d1 v0", bus.estado, bus.derrota, bus.vitoria); end
    total++; if ({bus.tentativas_restantes, bus.acertos} !== 8'h00)
      begin bad++; $display("FAIL lose_counts got=t%0d a%0d exp=t0 a0", bus.tentativas_restantes, bus.acertos); end
  endtask

  task automatic test_reset_mid_shot();
    int cf, cc, ic;
    pulse_iniciar();
    start_match();
    @(negedge clock);
    bus.coordColuna = 3'd0; bus.coordLinha = 3'd0; bus.botao_confirmar = 1'b1;
    @(negedge clock);
    bus.botao_confirmar = 1'b0;
    total++; if (bus.confirmar !== 1'b1) begin bad++; $display("FAIL mid_conf got=%0d exp=1", bus.confirmar); end
    reset = 1'b1;
    @(negedge clock);
    total++; if ({bus.estado, bus.enable, bus.confirmar, bus.acertos, bus.tentativas_restantes, bus.ultimo_acerto, bus.coord_invalida, bus.vitoria, bus.derrota} !== 18'b0)
      begin bad++; $display("FAIL mid_reset got=e%0d en%0d c%0d a%0d t%0d exp=all zero", bus.estado, bus.enable, bus.confirmar, bus.acertos, bus.tentativas_restantes); end
    reset = 1'b0;
    start_match();
    fire(3'd0, 3'd0, cf, cc, ic);
    total++; if (cc !== 1 || ic !== 0 || bus.acertos !== 4'd1)
      begin bad++; $display("FAIL mid_reshoot got=conf%0d inv%0d a%0d exp=conf1 inv0 a1", cc, ic, bus.acertos); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_miss();
    test_invalid();
    test_hold();
    test_victory();
    test_defeat();
    test_reset_mid_shot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_de_partida.md
Name: controlador_de_partida

Overview:
- Turn sequencer for one battleship match on the 5-column x 7-row LED board.
- Waits for a start request, then accepts player shots from the coordinate selector and the confirm button.
- Rejects out-of-range and repeated shots, and drives enable and a one-cycle confirmar pulse into gerenciador_de_ataque.
- Counts hits and remaining attempts, and declares victory or defeat.

Parameters:
MAX_TENTATIVAS, 10, attempts loaded at match start (1..15)
TOTAL_ALVOS, 8, number of ship cells in the map; reaching it means victory (1..15)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
iniciar  input  1  start/restart request, level sampled each cycle
botao_confirmar  input  1  confirm button, already synchronized and debounced; rising edge = one shot request
coordColuna  input  3  selected column, 0..4 valid
coordLinha  input  3  selected row, 0..6 valid
mapa0..mapa4  input  7 each  ship map per column; bit n = row n occupied
enable  output  1  enable for gerenciador_de_ataque
confirmar  output  1  registered one-cycle pulse to gerenciador_de_ataque
tentativas_restantes  output  4  attempts left
acertos  output  4  hits so far
ultimo_acerto  output  1  1 if the most recent accepted shot hit
coord_invalida  output  1  one-cycle pulse when a shot request is rejected
vitoria  output  1  high in VITORIA
derrota  output  1  high in DERROTA
estado  output  3  current state code, for the display logic

Behaviour:
- Reset (synchronous, active-high; wins over every other input, including mid-shot) sets:
  - estado = OCIOSO; enable = confirmar = coord_invalida = vitoria = derrota = ultimo_acerto = 0
  - acertos = 0, tentativas_restantes = 0
  - 35-bit shot register ja_atacado cleared; button edge register cleared
- Edge detect: borda = botao_confirmar & ~botao_anterior. botao_anterior is updated every cycle in every state. Edges seen outside JOGANDO are discarded; they are never queued.
- States (estado codes):
  - OCIOSO = 0
    - enable = 0.
    - iniciar = 1 -> JOGANDO next cycle; load tentativas_restantes = MAX_TENTATIVAS, acertos = 0, ja_atacado = 0, ultimo_acerto = 0.
  - JOGANDO = 1
    - enable = 1.
    - On borda, sample coordColuna and coordLinha in the same cycle.
    - Shot is invalid if coordColuna > 4, coordLinha > 6, or ja_atacado[coordColuna*7 + coordLinha] = 1. Invalid -> coord_invalida = 1 for exactly the next cycle; stay in JOGANDO; counters unchanged.
    - Valid -> latch coordinates; set the ja_atacado bit; -> DISPARO.
  - DISPARO = 2
    - confirmar = 1 for exactly this one cycle; enable stays 1.
    - acerto = mapa[col][lin] of the latched coordinates.
    - acertos += acerto (saturate at 15); tentativas_restantes -= 1; ultimo_acerto = acerto.
    - -> AVALIA.
  - AVALIA = 3
    - confirmar = 0; enable = 1.
    - acertos == TOTAL_ALVOS -> VITORIA. Win takes precedence even if tentativas_restantes == 0.
    - Else tentativas_restantes == 0 -> DERROTA.
    - Else -> JOGANDO.
  - VITORIA = 4
    - vitoria = 1; enable = 0.
    - iniciar -> OCIOSO.
  - DERROTA = 5
    - derrota = 1; enable = 0.
    - iniciar -> OCIOSO.
  - Codes 6 and 7 are illegal and go to OCIOSO.
- Latency: button edge at cycle N -> confirmar high at N+1 -> decision at N+2 -> JOGANDO, VITORIA or DERROTA from N+3.
- Minimum spacing between accepted shots is 3 cycles.
- confirmar never goes high outside DISPARO. It is never high two consecutive cycles.
- iniciar is ignored in JOGANDO, DISPARO and AVALIA.
- Clearing the revealed matrix in gerenciador_de_ataque is outside this block.

Test Plan:
- Maps: mapa0 = 1110001, mapa1 = 0100000, mapa2 = 0, mapa3 = 0, mapa4 = 1110000. Defaults MAX_TENTATIVAS = 10, TOTAL_ALVOS = 8.
- Reset then iniciar = 1 for one cycle -> estado = 1, tentativas_restantes = 10, acertos = 0, enable = 1, confirmar = 0.
- Shot (col 0, row 0) -> confirmar high exactly one cycle, one cycle after the edge; acertos = 1, ultimo_acerto = 1, tentativas = 9. Shot (2, 3) -> acertos = 1, ultimo_acerto = 0, tentativas = 8.
- Repeat (0, 0), then (5, 2), then (1, 7) -> three coord_invalida pulses, no confirmar, counters unchanged. Holding botao_confirmar high for 20 cycles -> exactly one shot.
- Hit all 8 targets within 10 shots, last hit on the 10th shot -> estado = 4, vitoria = 1 (not derrota), enable = 0; further button edges ignored; iniciar -> estado = 0.
- 10 water shots -> estado = 5, derrota = 1, tentativas_restantes = 0, acertos = 0.
- Assert reset the cycle confirmar is high -> next cycle all outputs at reset values, estado = 0, ja_atacado cleared (a previously shot cell is accepted again after restart).
